led_pattern_ctrl: RTL and testbench

//  Parametrised successor of the single LED-mode/time register pair. Sits after uart_cmd_decode on clk_25m.

---
 rtl/led_ctrl_pkg.sv | 32 +++
 rtl/led_timebase.sv | 87 ++++++++
 rtl/led_pattern_ctrl.sv | 163 ++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings, register offsets and reset defaults for led_pattern_ctrl.
// Optional brightness gating is enabled with `define LED_PWM_BRIGHT_EN.
package led_ctrl_pkg;

    localparam logic [3:0] MODE_OFF     = 4'd0;
    localparam logic [3:0] MODE_ON      = 4'd1;
    localparam logic [3:0] MODE_BLINK   = 4'd2;
    localparam logic [3:0] MODE_CHASE_L = 4'd3;
    localparam logic [3:0] MODE_CHASE_R = 4'd4;

    localparam logic [1:0] UNIT_1US   = 2'd0;
    localparam logic [1:0] UNIT_1MS   = 2'd1;
    localparam logic [1:0] UNIT_10MS  = 2'd2;
    localparam logic [1:0] UNIT_100MS = 2'd3;

    localparam logic [31:0] REG_MODE_OFS   = 32'd1;
    localparam logic [31:0] REG_TIME_OFS   = 32'd2;
    localparam logic [31:0] REG_BRIGHT_OFS = 32'd3;

    localparam logic [7:0] RST_TIME_NUM  = 8'd100;
    localparam logic [1:0] RST_TIME_UNIT = UNIT_1MS;
    localparam logic [2:0] RST_BRIGHT    = 3'd7;

    function automatic logic mode_legal(input logic [3:0] m);
        return m <= MODE_CHASE_R;
    endfunction

    function automatic logic unit_legal(input logic [3:0] u);
        return u <= {2'b00, UNIT_100MS};
    endfunction

endpackage

// File: rtl/led_timebase.sv
// Microsecond prescaler, 1ms/10ms/100ms cascade and step counter.
// step is a combinational 1-cycle strobe, suppressed while restart is asserted.
module led_timebase
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [7:0] time_num,
    input  logic [1:0] time_unit,
    output logic       step
);

    localparam int unsigned US_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRE_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(US_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [9:0]       us_cnt_q, us_cnt_d;
    logic [3:0]       ms_cnt_q, ms_cnt_d;
    logic [3:0]       ms10_cnt_q, ms10_cnt_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic             us_tick, ms_tick, ms10_tick, ms100_tick, unit_tick;
    logic [7:0]       step_max;

    always_comb begin
        us_tick    = (pre_q == PRE_MAX);
        ms_tick    = us_tick && (us_cnt_q == 10'd999);
        ms10_tick  = ms_tick && (ms_cnt_q == 4'd9);
        ms100_tick = ms10_tick && (ms10_cnt_q == 4'd9);

        case (time_unit)
            UNIT_1US:   unit_tick = us_tick;
            UNIT_1MS:   unit_tick = ms_tick;
            UNIT_10MS:  unit_tick = ms10_tick;
            UNIT_100MS: unit_tick = ms100_tick;
            default:    unit_tick = us_tick;
        endcase

        step_max = (time_num == 8'd0) ? 8'd1 : time_num;

        pre_d      = us_tick ? '0 : pre_q + PRE_W'(1);
        us_cnt_d   = us_tick ? (ms_tick ? '0 : us_cnt_q + 10'd1) : us_cnt_q;
        ms_cnt_d   = ms_tick ? (ms10_tick ? '0 : ms_cnt_q + 4'd1) : ms_cnt_q;
        ms10_cnt_d = ms10_tick ? (ms100_tick ? '0 : ms10_cnt_q + 4'd1) : ms10_cnt_q;

        step       = 1'b0;
        step_cnt_d = step_cnt_q;
        if (unit_tick) begin
            // counter never exceeds step_max-1, so the increment cannot wrap
            if (step_cnt_q + 8'd1 >= step_max) begin
                step       = 1'b1;
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + 8'd1;
            end
        end

        if (restart) begin
            step       = 1'b0;
            pre_d      = '0;
            us_cnt_d   = '0;
            ms_cnt_d   = '0;
            ms10_cnt_d = '0;
            step_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q      <= '0;
            us_cnt_q   <= '0;
            ms_cnt_q   <= '0;
            ms10_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            pre_q      <= pre_d;
            us_cnt_q   <= us_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            ms10_cnt_q <= ms10_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: MODE/TIME(/BRIGHT) registers, read mux and pattern generator.
// `define LED_PWM_BRIGHT_EN adds the BRIGHT register and frame-based output gating.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned NUM_LED     = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [31:0]        wr_addr,
    input  logic [15:0]        wr_data,
    input  logic               rd_en,
    input  logic [31:0]        rd_addr,
    output logic               rd_valid,
    output logic [15:0]        rd_data,
    output logic               rd_err,
    output logic               wr_err,
    output logic [NUM_LED-1:0] led_out
);

    logic [3:0]         mode_q, mode_d;
    logic [7:0]         time_num_q, time_num_d;
    logic [1:0]         time_unit_q, time_unit_d;
    logic [NUM_LED-1:0] pat_q, pat_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               rd_valid_q, rd_valid_d;
    logic [15:0]        rd_data_q, rd_data_d;
    logic               rd_err_q, rd_err_d;
    logic               wr_err_q, wr_err_d;
    logic               mode_wr_ok, time_wr_ok, bright_wr_ok, restart, step;
    logic               unused_wr_bits;
`ifdef LED_PWM_BRIGHT_EN
    logic [2:0]         bright_q, bright_d;
    logic [2:0]         frame_q, frame_d;
`endif

    assign unused_wr_bits = ^wr_data[7:4];

    function automatic logic [NUM_LED-1:0] pat_init(input logic [3:0] m);
        logic [NUM_LED-1:0] one;
        one = '0;
        one[0] = 1'b1;
        case (m)
            MODE_ON:      pat_init = '1;
            MODE_CHASE_L: pat_init = (NUM_LED == 1) ? '0 : one;
            MODE_CHASE_R: pat_init = (NUM_LED == 1) ? '0 : one << (NUM_LED - 1);
            default:      pat_init = '0;
        endcase
    endfunction

    // with a single LED the chase modes degenerate to blink
    function automatic logic [NUM_LED-1:0] pat_step(input logic [3:0] m,
                                                    input logic [NUM_LED-1:0] p);
        case (m)
            MODE_BLINK:   pat_step = ~p;
            MODE_CHASE_L: pat_step = (NUM_LED == 1) ? ~p : (p << 1) | (p >> (NUM_LED - 1));
            MODE_CHASE_R: pat_step = (NUM_LED == 1) ? ~p : (p >> 1) | (p << (NUM_LED - 1));
            default:      pat_step = p;
        endcase
    endfunction

    led_timebase #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .time_num (time_num_q),
        .time_unit(time_unit_q),
        .step     (step)
    );

    always_comb begin
        mode_wr_ok = wr_en && (wr_addr == BASE_ADDR + REG_MODE_OFS) && mode_legal(wr_data[3:0]);
        time_wr_ok = wr_en && (wr_addr == BASE_ADDR + REG_TIME_OFS) && unit_legal(wr_data[3:0]);
`ifdef LED_PWM_BRIGHT_EN
        bright_wr_ok = wr_en && (wr_addr == BASE_ADDR + REG_BRIGHT_OFS);
        bright_d     = bright_wr_ok ? wr_data[2:0] : bright_q;
        frame_d      = frame_q + 3'd1;
`else
        bright_wr_ok = 1'b0;
`endif
        restart  = mode_wr_ok || time_wr_ok;
        wr_err_d = wr_en && !(mode_wr_ok || time_wr_ok || bright_wr_ok);

        mode_d      = mode_wr_ok ? wr_data[3:0] : mode_q;
        time_num_d  = time_wr_ok ? wr_data[15:8] : time_num_q;
        time_unit_d = time_wr_ok ? wr_data[1:0] : time_unit_q;

        pat_d = pat_q;
        if (restart) begin
            pat_d = pat_init(mode_d);
        end else if (step) begin
            pat_d = pat_step(mode_q, pat_q);
        end

`ifdef LED_PWM_BRIGHT_EN
        led_d = (frame_d <= bright_d) ? pat_d : '0;
`else
        led_d = pat_d;
`endif

        // reads see the registers as they were before any same-cycle write
        rd_valid_d = rd_en;
        rd_data_d  = '0;
        rd_err_d   = 1'b0;
        if (rd_en) begin
            if (rd_addr == BASE_ADDR + REG_MODE_OFS) begin
                rd_data_d = {12'h000, mode_q};
            end else if (rd_addr == BASE_ADDR + REG_TIME_OFS) begin
                rd_data_d = {time_num_q, 4'h0, 2'b00, time_unit_q};
`ifdef LED_PWM_BRIGHT_EN
            end else if (rd_addr == BASE_ADDR + REG_BRIGHT_OFS) begin
                rd_data_d = {13'h0000, bright_q};
`endif
            end else begin
                rd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q      <= MODE_OFF;
            time_num_q  <= RST_TIME_NUM;
            time_unit_q <= RST_TIME_UNIT;
            pat_q       <= '0;
            led_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
            wr_err_q    <= 1'b0;
`ifdef LED_PWM_BRIGHT_EN
            bright_q    <= RST_BRIGHT;
            frame_q     <= '0;
`endif
        end else begin
            mode_q      <= mode_d;
            time_num_q  <= time_num_d;
            time_unit_q <= time_unit_d;
            pat_q       <= pat_d;
            led_q       <= led_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_err_q    <= rd_err_d;
            wr_err_q    <= wr_err_d;
`ifdef LED_PWM_BRIGHT_EN
            bright_q    <= bright_d;
            frame_q     <= frame_d;
`endif
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;
    assign led_out  = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: directed and random register traffic,
// expected LED pattern derived from elapsed time since the last restart.
module tb_led_pattern_ctrl;

    localparam int unsigned NL   = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [31:0]   rd_addr = '0;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic          rd_err;
    logic          wr_err;
    logic [NL-1:0] led_out;

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .CLK_FREQ_HZ(4_000_000),
        .NUM_LED    (NL),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_err  (rd_err),
        .wr_err  (wr_err),
        .led_out (led_out)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned eff;
        int unsigned mode, tn, unit, bright;
        bit          restart;
    } upd_t;
    typedef struct {
        int unsigned eff;
        logic [15:0] data;
        logic        err;
    } rd_exp_t;
    typedef struct {
        int unsigned eff;
        logic        err;
    } wr_exp_t;

    upd_t    upd_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    // architectural view as seen by the stimulus side
    int unsigned sh_mode, sh_tn, sh_unit, sh_bright;
    // state the monitor has committed for the LED model
    int unsigned m_mode, m_tn, m_unit, m_bright, m_start, rst_cyc;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int unsigned unit_us(input int unsigned u);
        case (u)
            0: return 1;
            1: return 1000;
            2: return 10000;
            default: return 100000;
        endcase
    endfunction

    function automatic logic [NL-1:0] exp_led();
        int unsigned per, steps;
        logic [NL-1:0] p, one;
        one = 1;
        per = ((m_tn == 0) ? 1 : m_tn) * unit_us(m_unit) * 4;
        steps = (cyc - m_start) / per;
        case (m_mode)
            1: p = '1;
            2: p = (steps % 2 == 1) ? '1 : '0;
            3: p = one << (steps % NL);
            4: p = one << (NL - 1 - (steps % NL));
            default: p = '0;
        endcase
`ifdef LED_PWM_BRIGHT_EN
        if (((cyc - rst_cyc) % 8) > m_bright) p = '0;
`endif
        return p;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (upd_q.size() > 0 && upd_q[0].eff <= cyc) begin
                upd_t u;
                u = upd_q.pop_front();
                m_mode = u.mode; m_tn = u.tn; m_unit = u.unit; m_bright = u.bright;
                if (u.restart) m_start = u.eff;
            end
            chk("led_out", 32'(led_out), 32'(exp_led()));

            if (wr_q.size() > 0 && wr_q[0].eff == cyc) begin
                wr_exp_t w;
                w = wr_q.pop_front();
                chk("wr_err", 32'(wr_err), 32'(w.err));
            end else begin
                chk("wr_err_idle", 32'(wr_err), 32'd0);
            end

            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk("rd_latency", cyc, r.eff);
                    chk("rd_data", 32'(rd_data), 32'(r.data));
                    chk("rd_err", 32'(rd_err), 32'(r.err));
                end
            end
            if (rd_q.size() > 0 && rd_q[0].eff < cyc) begin
                void'(rd_q.pop_front());
                chk("rd_timeout", 32'd0, 32'd1);
            end
        end
    end

    task automatic do_op(input bit we, input logic [31:0] wa, input logic [15:0] wd,
                         input bit re, input logic [31:0] ra);
        int unsigned eff;
        rd_exp_t r;
        wr_exp_t w;
        upd_t u;
        @(posedge clk); #1;
        eff = cyc + 1;
        if (re) begin
            r.eff = eff; r.data = '0; r.err = 1'b0;
            if (ra == BASE + 1) r.data = {12'h0, 4'(sh_mode)};
            else if (ra == BASE + 2) r.data = {8'(sh_tn), 4'h0, 4'(sh_unit)};
`ifdef LED_PWM_BRIGHT_EN
            else if (ra == BASE + 3) r.data = {13'h0, 3'(sh_bright)};
`endif
            else r.err = 1'b1;
            rd_q.push_back(r);
        end
        if (we) begin
            w.eff = eff; w.err = 1'b1;
            u.eff = eff; u.restart = 1'b0;
            if (wa == BASE + 1 && wd[3:0] <= 4) begin
                sh_mode = wd[3:0]; w.err = 1'b0; u.restart = 1'b1;
            end else if (wa == BASE + 2 && wd[3:0] <= 3) begin
                sh_tn = wd[15:8]; sh_unit = wd[3:0]; w.err = 1'b0; u.restart = 1'b1;
            end
`ifdef LED_PWM_BRIGHT_EN
            else if (wa == BASE + 3) begin
                sh_bright = wd[2:0]; w.err = 1'b0;
            end
`endif
            u.mode = sh_mode; u.tn = sh_tn; u.unit = sh_unit; u.bright = sh_bright;
            if (!w.err) upd_q.push_back(u);
            wr_q.push_back(w);
        end
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [15:0] d);
        do_op(1'b1, BASE + ofs, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [31:0] ofs);
        do_op(1'b0, '0, '0, 1'b1, BASE + ofs);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        sh_mode = 0; sh_tn = 100; sh_unit = 1; sh_bright = 7;
        m_mode = 0; m_tn = 100; m_unit = 1; m_bright = 7; m_start = 0; rst_cyc = 0;

        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_led", 32'(led_out), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_err", 32'(rd_err), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_wr_err", 32'(wr_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rst_cyc = cyc;
        m_start = cyc;
        mon_en = 1'b1;

        rd(1); rd(2);
        wr(2, 16'h0300); wr(1, 16'h0002); idle(40);
        wr(1, 16'h0003); wr(2, 16'h0100); idle(20);
        wr(1, 16'h0004); idle(20);
        wr(1, 16'h0007); wr(2, 16'h1205); rd(1); rd(2);
        rd(9);
        do_op(1'b1, BASE + 1, 16'h0001, 1'b1, BASE + 1);
        rd(1); idle(5);
        wr(1, 16'h0001); wr(3, 16'h0001); rd(3); idle(24);
        wr(3, 16'h0007); idle(4);
        wr(0, 16'h0001); rd(0);
        wr(2, 16'h0101); wr(1, 16'h0003); idle(8100);
        wr(2, 16'h0000); wr(1, 16'h0002); idle(10);

        for (int i = 0; i < 250; i++) begin
            int unsigned op;
            logic [15:0] d;
            logic [31:0] ofs;
            op = $urandom_range(0, 9);
            d = 16'($urandom);
            case (op)
                0, 1, 2: begin
                    d[3:0] = 4'($urandom_range(0, 7));
                    wr(1, d);
                end
                3, 4: begin
                    d[15:8] = 8'($urandom_range(0, 5));
                    d[3:0] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'd0;
                    wr(2, d);
                end
                5: begin
                    ofs = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(4, 20));
                    wr(ofs, d);
                end
                6, 7: rd(32'($urandom_range(0, 5)));
                8: begin
                    ofs = 32'($urandom_range(1, 3));
                    d[3:0] = 4'($urandom_range(0, 5));
                    do_op(1'b1, BASE + ofs, d, 1'b1, BASE + ofs);
                end
                default: wr(3, d);
            endcase
            idle($urandom_range(0, 30));
        end

        idle(10);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
